// File: rtl/seg_pipe_adder_pkg.sv
// Segment geometry helpers shared by the segmented pipelined adder and its stages.
package seg_pipe_adder_pkg;

    function automatic int nseg(input int width, input int seg_width);
        return (width + seg_width - 1) / seg_width;
    endfunction

    function automatic int seg_lo(input int k, input int seg_width);
        return k * seg_width;
    endfunction

    // The last segment absorbs whatever is left once the full segments are taken.
    function automatic int seg_w(input int k, input int width, input int seg_width);
        return (k == nseg(width, seg_width) - 1) ? width - k * seg_width : seg_width;
    endfunction

endpackage

// File: rtl/seg_pipe_adder_stage.sv
// One pipeline stage: resolves segment K of the sum and registers it with the
// carry, the valid bit and the operands still needed by later stages.
module seg_pipe_adder_stage
    import seg_pipe_adder_pkg::*;
#(
    parameter int WIDTH     = 13,
    parameter int SEG_WIDTH = 4,
    parameter int K         = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_up,
    input  logic             load_dn,
    input  logic [WIDTH-1:0] a_up,
    input  logic [WIDTH-1:0] b_up,
    input  logic [WIDTH-1:0] sum_up,
    input  logic             carry_up,
    output logic             valid,
    output logic             load,
    output logic [WIDTH-1:0] a_hold,
    output logic [WIDTH-1:0] b_hold,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    localparam int LO = seg_lo(K, SEG_WIDTH);
    localparam int SW = seg_w(K, WIDTH, SEG_WIDTH);

    logic             valid_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [SW:0]      seg_sum;
    logic [WIDTH-1:0] sum_next;

    always_comb begin
        seg_sum  = {1'b0, a_up[LO +: SW]} + {1'b0, b_up[LO +: SW]} + {{SW{1'b0}}, carry_up};
        sum_next = sum_up;
        sum_next[LO +: SW] = seg_sum[SW-1:0];
    end

    // An empty stage always loads, which is what lets bubbles collapse under a stall.
    assign load = !valid_reg || load_dn;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
        end else if (load) begin
            valid_reg <= valid_up;
            if (valid_up) begin
                carry_reg <= seg_sum[SW];
                a_reg     <= a_up;
                b_reg     <= b_up;
                sum_reg   <= sum_next;
            end
        end
    end

    assign valid  = valid_reg;
    assign carry  = carry_reg;
    assign a_hold = a_reg;
    assign b_hold = b_reg;
    assign sum    = sum_reg;

endmodule

// File: rtl/seg_pipe_adder.sv
// Pipelined segmented adder/subtractor with valid/ready flow control.
// Optional signed-overflow output enabled by SEG_PIPE_ADDER_OVF_DETECT_EN.
module seg_pipe_adder
    import seg_pipe_adder_pkg::*;
#(
    parameter int WIDTH     = 13,
    parameter int SEG_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SEG_PIPE_ADDER_OVF_DETECT_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSEG = nseg(WIDTH, SEG_WIDTH);

    logic [NSEG:0]    valid_chain;
    logic [NSEG:0]    load_chain;
    logic [NSEG:0]    carry_chain;
    logic [WIDTH-1:0] a_chain   [0:NSEG];
    logic [WIDTH-1:0] b_chain   [0:NSEG];
    logic [WIDTH-1:0] sum_chain [0:NSEG];
    logic [WIDTH-1:0] a_unused;
    logic [WIDTH-1:0] b_unused;

    // Subtraction is a + ~b + ~cin, so the borrow-in becomes an inverted carry-in.
    assign valid_chain[0] = in_valid;
    assign carry_chain[0] = sub ? ~cin : cin;
    assign a_chain[0]     = a;
    assign b_chain[0]     = sub ? ~b : b;
    assign sum_chain[0]   = '0;
    assign load_chain[NSEG] = out_ready;

    for (genvar gi = 0; gi < NSEG; gi++) begin : g_stage
        seg_pipe_adder_stage #(
            .WIDTH     (WIDTH),
            .SEG_WIDTH (SEG_WIDTH),
            .K         (gi)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .valid_up (valid_chain[gi]),
            .load_dn  (load_chain[gi+1]),
            .a_up     (a_chain[gi]),
            .b_up     (b_chain[gi]),
            .sum_up   (sum_chain[gi]),
            .carry_up (carry_chain[gi]),
            .valid    (valid_chain[gi+1]),
            .load     (load_chain[gi]),
            .a_hold   (a_chain[gi+1]),
            .b_hold   (b_chain[gi+1]),
            .sum      (sum_chain[gi+1]),
            .carry    (carry_chain[gi+1])
        );
    end

    assign in_ready  = load_chain[0];
    assign out_valid = valid_chain[NSEG];
    assign s         = sum_chain[NSEG];
    assign cout      = carry_chain[NSEG];

    // Operands leaving the last stage are only needed for their MSBs.
    assign a_unused = a_chain[NSEG];
    assign b_unused = b_chain[NSEG];

`ifdef SEG_PIPE_ADDER_OVF_DETECT_EN
    assign ovf = (a_chain[NSEG][WIDTH-1] == b_chain[NSEG][WIDTH-1])
              && (s[WIDTH-1] != a_chain[NSEG][WIDTH-1]);
`endif

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed bench for seg_pipe_adder (13-bit, 4-bit segments) plus a single-stage instance.
module tb_seg_pipe_adder;

    localparam int W = 13;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic         in_ready, out_valid, cout;
    logic [W-1:0] s;
    logic         in_ready1, out_valid1, cout1;
    logic [W-1:0] s1;
`ifdef SEG_PIPE_ADDER_OVF_DETECT_EN
    logic         ovf, ovf1;
`endif

    seg_pipe_adder #(.WIDTH(W), .SEG_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
`ifdef SEG_PIPE_ADDER_OVF_DETECT_EN
        , .ovf(ovf)
`endif
    );

    seg_pipe_adder #(.WIDTH(W), .SEG_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready), .s(s1), .cout(cout1)
`ifdef SEG_PIPE_ADDER_OVF_DETECT_EN
        , .ovf(ovf1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic         vsub;
        logic [W-1:0] vs;
        logic         vcout;
        logic         vovf;
    } vec_t;

    vec_t         vecs [11];
    int           total = 0;
    int           bad = 0;
    int           n_acc = 0;
    int           n_cons = 0;
    logic         mon_en = 1'b0;
    logic         acc_flag = 1'b0;
    logic [W:0]   q [$];
    logic [W:0]   exp_v;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endfunction

    // Reference: plain add, or subtract with cout = no-borrow.
    function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic mc, input logic ms);
        logic [W:0] d;
        if (!ms) return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        d = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mc};
        return {~d[W], d[W-1:0]};
    endfunction

    // Scoreboard: record accepted beats, compare consumed results in order.
    always @(negedge clk) begin
        acc_flag = 1'b0;
        if (!rst && mon_en) begin
            if (in_valid && in_ready) begin
                acc_flag = 1'b1;
                n_acc++;
                q.push_back(model(a, b, cin, sub));
            end
            if (out_valid && out_ready) begin
                n_cons++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL stream_extra: got unexpected result s=%0h want none", s);
                end else begin
                    exp_v = q.pop_front();
                    chk("stream_s", 32'(s), 32'(exp_v[W-1:0]));
                    chk("stream_cout", 32'(cout), 32'(exp_v[W]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic new_beat();
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        a = v.va; b = v.vb; cin = v.vcin; sub = v.vsub;
        in_valid = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        n = 1;
        chk({tag, "_nseg1_valid"}, 32'(out_valid1), 32'd1);
        chk({tag, "_nseg1_s"}, 32'(s1), 32'(v.vs));
        chk({tag, "_nseg1_cout"}, 32'(cout1), 32'(v.vcout));
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd4);
        chk({tag, "_s"}, 32'(s), 32'(v.vs));
        chk({tag, "_cout"}, 32'(cout), 32'(v.vcout));
`ifdef SEG_PIPE_ADDER_OVF_DETECT_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(v.vovf));
`endif
        step();
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
        $display("vec %s: a=%h b=%h cin=%0d sub=%0d -> s=%h cout=%0d lat=%0d",
                 tag, v.va, v.vb, v.vcin, v.vsub, s1, cout1, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   drain;
        int   acc0;
        int   cons0;
        logic have;
        logic [W-1:0] held;

        //          a         b         cin   sub   s         cout  ovf
        vecs[0]  = {13'h1FFF, 13'h0001, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b0};
        vecs[1]  = {13'h0005, 13'h0007, 1'b0, 1'b1, 13'h1FFE, 1'b0, 1'b0};
        vecs[2]  = {13'h0005, 13'h0007, 1'b1, 1'b1, 13'h1FFD, 1'b0, 1'b0};
        vecs[3]  = {13'h0FFF, 13'h0001, 1'b0, 1'b0, 13'h1000, 1'b0, 1'b1};
        vecs[4]  = {13'h1000, 13'h1FFF, 1'b0, 1'b0, 13'h0FFF, 1'b1, 1'b1};
        vecs[5]  = {13'h0003, 13'h0004, 1'b0, 1'b0, 13'h0007, 1'b0, 1'b0};
        vecs[6]  = {13'h0000, 13'h0000, 1'b1, 1'b0, 13'h0001, 1'b0, 1'b0};
        vecs[7]  = {13'h1234, 13'h1234, 1'b0, 1'b1, 13'h0000, 1'b1, 1'b0};
        vecs[8]  = {13'h0AAA, 13'h0555, 1'b1, 1'b0, 13'h1000, 1'b0, 1'b1};
        vecs[9]  = {13'h0000, 13'h0000, 1'b1, 1'b1, 13'h1FFF, 1'b0, 1'b0};
        vecs[10] = {13'h1000, 13'h0001, 1'b0, 1'b1, 13'h0FFF, 1'b1, 1'b1};

        // Reset state
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        step();

        for (int i = 0; i < 11; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Back-to-back stream at full rate
        mon_en = 1'b1;
        out_ready = 1'b1;
        cons0 = n_cons;
        for (int i = 0; i < 16; i++) begin
            new_beat();
            in_valid = 1'b1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        drain = 0;
        while (q.size() != 0 && drain < 20) begin
            step();
            drain++;
        end
        chk("stream_count", 32'(n_cons - cons0), 32'd16);
        chk("stream_drain", 32'(drain), 32'd4);
        $display("stream: 16 beats, drain=%0d consumed=%0d", drain, n_cons - cons0);

        // Fill under stall, then gaps with toggling out_ready
        out_ready = 1'b0;
        acc0 = n_acc;
        have = 1'b0;
        held = '0;
        new_beat();
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (acc_flag) new_beat();
            if (have) chk("stall_hold_s", 32'(s), 32'(held));
            if (out_valid && !have) begin
                have = 1'b1;
                held = s;
            end
        end
        chk("stall_accepts", 32'(n_acc - acc0), 32'd4);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
        $display("stall: accepts=%0d held s=%h", n_acc - acc0, held);
        for (int c = 0; c < 10; c++) begin
            in_valid  = (c != 3);
            out_ready = c[0];
            step();
            if (acc_flag) new_beat();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain = 0;
        while (q.size() != 0 && drain < 30) begin
            step();
            drain++;
        end
        chk("stall_q_empty", 32'(q.size()), 32'd0);
        chk("stall_balance", 32'(n_cons), 32'(n_acc));
        $display("gap/toggle: accepted=%0d consumed=%0d", n_acc, n_cons);

        // Asynchronous reset with three beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            new_beat();
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_s", 32'(s), 32'd0);
        chk("midrst_cout", 32'(cout), 32'd0);
        q.delete();
        mon_en = 1'b0;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        $display("mid reset: pipeline flushed");
        run_vec({13'd100, 13'd23, 1'b0, 1'b0, 13'd123, 1'b0, 1'b0}, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
